databus_arbiter: RTL and testbench

//   Round-robin arbiter/sequencer for the shared 12-bit tri-state Data_bus.
//   Up to NUM_REQ bus agents request a transfer; the arbiter drives exactly one

---
 rtl/databus_arbiter.sv | 153 +++++++++++++++
 tb/tb_databus_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/databus_arbiter.sv
// databus_arbiter
// Round-robin sequencer for the shared 12-bit tri-state Data_bus. It grants one
// agent at a time. The granted agent drives the bus for SETTLE_CYCLES, then a
// write strobe is pulsed while the drive is still held. After that, a bus-idle
// turnaround gap of TURN_CYCLES is forced before the next grant. Every output
// is a register.

module databus_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int SETTLE_CYCLES = 1,
    parameter int TURN_CYCLES   = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         link_bus,
    output logic                       write,
    output logic [NUM_REQ-1:0]         ack,
    output logic [$clog2(NUM_REQ)-1:0] gnt_id,
    output logic                       busy
);

    localparam int IDW = $clog2(NUM_REQ);

    // Counter preloads: a value of N-1 gives a phase that lasts exactly N cycles.
    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0] TURN_INIT   = 4'(TURN_CYCLES - 1);

    // Reject illegal parameter values at elaboration time.
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("databus_arbiter: NUM_REQ must be in 2..8");
    end
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("databus_arbiter: SETTLE_CYCLES must be in 1..15");
    end
    if (TURN_CYCLES < 1 || TURN_CYCLES > 15) begin : g_bad_turn
        $error("databus_arbiter: TURN_CYCLES must be in 1..15");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        STROBE = 2'd2,
        TURN   = 2'd3
    } state_t;

    state_t         state;
    logic [3:0]     cnt;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] win;

    // First requesting agent found when searching upward from the pointer,
    // wrapping past the top. The pointer sets the priority of simultaneous
    // requests, which guarantees that every agent is eventually served.
    function automatic logic [IDW-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDW-1:0]     p);
        logic [IDW-1:0] w;
        logic [IDW-1:0] idx;
        logic           found;
        int             idx_i;
        w     = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_i = (int'(p) + k) % NUM_REQ;
            idx   = IDW'(idx_i);
            if (!found && r[idx]) begin
                w     = idx;
                found = 1'b1;
            end
        end
        return w;
    endfunction

    // Pointer value after a transfer: the slot following the agent just served.
    function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] g);
        int n;
        n = (int'(g) + 1) % NUM_REQ;
        return IDW'(n);
    endfunction

    // Bus-enable pattern for a single agent.
    function automatic logic [NUM_REQ-1:0] to_onehot(input logic [IDW-1:0] i);
        logic [NUM_REQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Combinational winner selection; it is used only when the FSM is in IDLE.
    always_comb begin
        win = rr_pick(req, ptr);
    end

    // Sequencer FSM. Reset is asynchronous, so link_bus drops the moment
    // rst_n falls, even in the middle of a transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            link_bus <= '0;
            write    <= 1'b0;
            ack      <= '0;
            gnt_id   <= '0;
            busy     <= 1'b0;
            cnt      <= '0;
            ptr      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Requests are sampled only here. Requests raised later wait for the next IDLE.
                    if (|req) begin
                        state    <= SETTLE;
                        link_bus <= to_onehot(win);
                        gnt_id   <= win;
                        busy     <= 1'b1;
                        cnt      <= SETTLE_INIT;
                    end
                end
                SETTLE: begin
                    // Hold the drive enable until the bus has settled.
                    if (cnt == 4'd0) begin
                        state <= STROBE;
                        write <= 1'b1;
                        ack   <= link_bus;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                STROBE: begin
                    // One-cycle strobe. The bus is released on the next edge.
                    state    <= TURN;
                    link_bus <= '0;
                    write    <= 1'b0;
                    ack      <= '0;
                    ptr      <= next_ptr(gnt_id);
                    cnt      <= TURN_INIT;
                end
                TURN: begin
                    // No agent drives the bus during turnaround. gnt_id keeps its value.
                    if (cnt == 4'd0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_databus_arbiter.sv
// tb_databus_arbiter
// Directed bench for databus_arbiter. It has two instances: one with the
// default timing and one with SETTLE_CYCLES=3 and TURN_CYCLES=2. Inputs are
// driven, and outputs sampled, 1 time unit after each rising edge.

module tb_databus_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] link_bus;
    logic       write;
    logic [3:0] ack;
    logic [1:0] gnt_id;
    logic       busy;

    logic [3:0] req2;
    logic [3:0] link_bus2;
    logic       write2;
    logic [3:0] ack2;
    logic [1:0] gnt_id2;
    logic       busy2;

    int n_checks = 0;
    int n_fail   = 0;

    databus_arbiter #(.NUM_REQ(4), .SETTLE_CYCLES(1), .TURN_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .link_bus(link_bus),
        .write(write), .ack(ack), .gnt_id(gnt_id), .busy(busy)
    );

    databus_arbiter #(.NUM_REQ(4), .SETTLE_CYCLES(3), .TURN_CYCLES(2)) dut_slow (
        .clk(clk), .rst_n(rst_n), .req(req2), .link_bus(link_bus2),
        .write(write2), .ack(ack2), .gnt_id(gnt_id2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        req   = 4'b1111;
        req2  = 4'b0000;
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({link_bus, write, ack, gnt_id, busy} !== 12'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got link=%b wr=%b ack=%b gnt=%0d busy=%b, want all 0",
                     link_bus, write, ack, gnt_id, busy);
        end
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (link_bus !== 4'b0001 || gnt_id !== 2'd0 || busy !== 1'b1 || write !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_first_grant: got link=%b gnt=%0d busy=%b wr=%b, want 0001/0/1/0",
                     link_bus, gnt_id, busy, write);
        end
    endtask

    task automatic test_single();
        req = 4'b0000;
        do_reset();
        req = 4'b0100;
        tick(); // SETTLE
        n_checks++;
        if (link_bus !== 4'b0100 || write !== 1'b0 || ack !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_settle: got link=%b wr=%b ack=%b, want 0100/0/0000", link_bus, write, ack);
        end
        tick(); // STROBE
        n_checks++;
        if (link_bus !== 4'b0100 || write !== 1'b1 || ack !== 4'b0100) begin
            n_fail++;
            $display("FAIL single_strobe: got link=%b wr=%b ack=%b, want 0100/1/0100", link_bus, write, ack);
        end
        tick(); // TURN
        n_checks++;
        if (link_bus !== 4'b0000 || write !== 1'b0 || ack !== 4'b0000 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_turn: got link=%b wr=%b ack=%b busy=%b, want 0000/0/0000/1",
                     link_bus, write, ack, busy);
        end
        tick(); // IDLE
        n_checks++;
        if (link_bus !== 4'b0000 || busy !== 1'b0 || gnt_id !== 2'd2) begin
            n_fail++;
            $display("FAIL single_idle: got link=%b busy=%b gnt=%0d, want 0000/0/2", link_bus, busy, gnt_id);
        end
        tick(); // SETTLE again, period 4
        n_checks++;
        if (link_bus !== 4'b0100 || gnt_id !== 2'd2) begin
            n_fail++;
            $display("FAIL single_regrant: got link=%b gnt=%0d, want 0100/2", link_bus, gnt_id);
        end
        req = 4'b0000;
    endtask

    task automatic test_round_robin();
        int         order [5];
        logic [3:0] exp;
        order = '{0, 1, 2, 3, 0};
        req   = 4'b1111;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            exp = 4'b0001 << order[i];
            tick();
            n_checks++;
            if (link_bus !== exp || gnt_id !== 2'(order[i])) begin
                n_fail++;
                $display("FAIL rr_grant%0d: got link=%b gnt=%0d, want %b/%0d", i, link_bus, gnt_id, exp, order[i]);
            end
            tick();
            n_checks++;
            if (write !== 1'b1 || ack !== exp || link_bus !== exp) begin
                n_fail++;
                $display("FAIL rr_strobe%0d: got wr=%b ack=%b link=%b, want 1/%b/%b", i, write, ack, link_bus, exp, exp);
            end
            tick();
            n_checks++;
            if (link_bus !== 4'b0000 || write !== 1'b0 || ack !== 4'b0000) begin
                n_fail++;
                $display("FAIL rr_turn%0d: got link=%b wr=%b ack=%b, want all 0", i, link_bus, write, ack);
            end
            tick();
            n_checks++;
            if (link_bus !== 4'b0000 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rr_idle%0d: got link=%b busy=%b, want 0000/0", i, link_bus, busy);
            end
        end
        req = 4'b0000;
    endtask

    task automatic test_drop_req();
        int ack1_count;
        ack1_count = 0;
        req = 4'b0000;
        do_reset();
        req = 4'b0010;
        tick(); // SETTLE, agent 1
        n_checks++;
        if (link_bus !== 4'b0010 || gnt_id !== 2'd1) begin
            n_fail++;
            $display("FAIL drop_grant: got link=%b gnt=%0d, want 0010/1", link_bus, gnt_id);
        end
        req = 4'b1001; // drop agent 1, raise agents 0 and 3
        for (int c = 0; c < 3; c++) begin // STROBE, TURN, IDLE
            tick();
            if (ack[1] === 1'b1) ack1_count++;
        end
        n_checks++;
        if (ack1_count != 1) begin
            n_fail++;
            $display("FAIL drop_ack_once: got %0d ack[1] pulses, want 1", ack1_count);
        end
        tick(); // next grant: search starts at agent 2, so agent 3 wins
        n_checks++;
        if (link_bus !== 4'b1000 || gnt_id !== 2'd3) begin
            n_fail++;
            $display("FAIL drop_next_grant: got link=%b gnt=%0d, want 1000/3", link_bus, gnt_id);
        end
        req = 4'b0000;
    endtask

    task automatic test_async_reset();
        req = 4'b0000;
        do_reset();
        req = 4'b0100;
        repeat (5) tick(); // the first transfer completes; the second reaches SETTLE
        tick();            // STROBE of the second transfer; pointer is 3
        n_checks++;
        if (write !== 1'b1 || link_bus !== 4'b0100) begin
            n_fail++;
            $display("FAIL areset_pre_strobe: got wr=%b link=%b, want 1/0100", write, link_bus);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (link_bus !== 4'b0000 || write !== 1'b0 || ack !== 4'b0000 || busy !== 1'b0 || gnt_id !== 2'd0) begin
            n_fail++;
            $display("FAIL areset_no_clk: got link=%b wr=%b ack=%b busy=%b gnt=%0d, want all 0",
                     link_bus, write, ack, busy, gnt_id);
        end
        tick();
        req   = 4'b1010;
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (link_bus !== 4'b0010 || gnt_id !== 2'd1) begin
            n_fail++;
            $display("FAIL areset_ptr_zero: got link=%b gnt=%0d, want 0010/1", link_bus, gnt_id);
        end
        req = 4'b0000;
    endtask

    task automatic test_slow_timing();
        int gap;
        req  = 4'b0000;
        req2 = 4'b0000;
        do_reset();
        req2 = 4'b0001;
        for (int c = 0; c < 4; c++) begin
            tick();
            n_checks++;
            if (link_bus2 !== 4'b0001 || write2 !== (c == 3)) begin
                n_fail++;
                $display("FAIL slow_cycle%0d: got link=%b wr=%b, want 0001/%0d", c, link_bus2, write2, (c == 3));
            end
        end
        gap = 0;
        tick();
        while (write2 !== 1'b1 && gap < 20) begin
            gap++;
            tick();
        end
        n_checks++;
        if (gap != 6) begin
            n_fail++;
            $display("FAIL slow_write_gap: got %0d cycles between write pulses, want 6", gap);
        end
        req2 = 4'b0000;
    endtask

    // Invariants are checked on every sampled cycle while the tests run.
    logic inv_on = 1'b0;
    always @(posedge clk) begin
        #2;
        if (inv_on) begin
            n_checks++;
            if (!$onehot0(link_bus) || (write && !$onehot(link_bus)) ||
                ack !== (link_bus & {4{write}}) || !$onehot0(link_bus2)) begin
                n_fail++;
                $display("FAIL invariant: got link=%b wr=%b ack=%b link2=%b", link_bus, write, ack, link_bus2);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        req2  = 4'b0000;
        test_reset();
        inv_on = 1'b1;
        test_single();
        test_round_robin();
        test_drop_req();
        test_async_reset();
        test_slow_timing();
        inv_on = 1'b0;
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
